// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory/cache (slave).
// Request fields are valid while dreq is high; drdata is valid with ddata_ok for loads.
interface mem_access_stage_if;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstrb;
    logic        daddr_ok;
    logic        ddata_ok;
    logic [31:0] drdata;

    modport master (
        output dreq, dwr, dsize, daddr, dwdata, dwstrb,
        input  daddr_ok, ddata_ok, drdata
    );

    modport slave (
        input  dreq, dwr, dsize, daddr, dwdata, dwstrb,
        output daddr_ok, ddata_ok, drdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues loads/stores on the data bus,
// aligns load data, detects address errors and registers the MEM/WB outputs.
module mem_access_stage #(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic                 flush,
    input  logic [DW-1:0]        pc,
    input  logic [DW-1:0]        exe_data,
    input  logic [DW-1:0]        busB,
    input  logic [3:0]           mem_rd_en,
    input  logic [3:0]           mem_wr_en,
    input  logic                 ld_signed,
    input  logic                 mem_to_reg,
    input  logic                 reg_wen,
    input  logic [4:0]           reg_num,
    input  logic                 cp0_wen,
    input  logic [4:0]           cp0_num,
    input  logic [2:0]           cp0_sel,
    mem_access_stage_if.master   dbus,
    output logic                 stall_out,
    output logic [DW-1:0]        fwd_data,
    output logic [DW-1:0]        wb_pc,
    output logic [DW-1:0]        wb_data,
    output logic                 wb_reg_wen,
    output logic [4:0]           wb_reg_num,
    output logic                 wb_cp0_wen,
    output logic [4:0]           wb_cp0_num,
    output logic [2:0]           wb_cp0_sel,
    output logic                 wb_adel,
    output logic                 wb_ades,
    output logic [DW-1:0]        wb_badvaddr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_reg, state_next;
    logic        killed_reg, killed_next;

    logic [3:0]  size_en;
    logic        is_byte, is_half, is_word;
    logic        mem_op, misaligned;
    logic [1:0]  a_lo;
    logic        dreq_int, dwr_int;
    logic [31:0] dwdata_int;
    logic [3:0]  dwstrb_int;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        wb_kill;

    assign size_en    = mem_rd_en | mem_wr_en;
    assign is_byte    = (size_en == 4'b0001);
    assign is_half    = (size_en == 4'b0011);
    assign is_word    = (size_en == 4'b1111);
    assign mem_op     = |size_en;
    assign a_lo       = exe_data[1:0];
    assign misaligned = (is_half & a_lo[0]) | (is_word & (a_lo != 2'b00));

    assign dreq_int = ((state_reg == S_IDLE) & mem_op & ~misaligned & ~flush)
                    | (state_reg == S_REQ);
    assign dwr_int  = |mem_wr_en;

    // Per-lane store data replication and byte strobes
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign dwdata_int[8*gi +: 8] = is_word ? busB[8*gi +: 8] :
                                       is_half ? busB[8*(gi%2) +: 8] :
                                                 busB[7:0];
        assign dwstrb_int[gi] = dwr_int & (is_word
                              | (is_half & (a_lo[1] == LANE[1]))
                              | (is_byte & (a_lo == LANE)));
    end

    assign dbus.dreq   = dreq_int;
    assign dbus.dwr    = dwr_int;
    assign dbus.dsize  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    assign dbus.daddr  = exe_data;
    assign dbus.dwdata = dwdata_int;
    assign dbus.dwstrb = dwstrb_int;

    assign ld_byte = dbus.drdata[{a_lo, 3'b000} +: 8];
    assign ld_half = dbus.drdata[{a_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = dbus.drdata;
        if (is_byte)
            ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
        else if (is_half)
            ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
    end

    assign fwd_data = mem_to_reg ? ld_data : exe_data;

    // The completion cycle (WAIT with ddata_ok) releases the pipe so WB captures the data
    assign stall_out = (state_reg == S_REQ)
                     | ((state_reg == S_WAIT) & ~dbus.ddata_ok)
                     | ((state_reg == S_IDLE) & mem_op & ~misaligned & ~flush);

    always_comb begin
        state_next  = state_reg;
        killed_next = killed_reg;
        case (state_reg)
            S_IDLE: begin
                if (dreq_int) begin
                    state_next  = dbus.daddr_ok ? S_WAIT : S_REQ;
                    killed_next = 1'b0;
                end
            end
            S_REQ: begin
                if (dbus.daddr_ok) begin
                    state_next  = S_WAIT;
                    killed_next = killed_reg | flush;
                end else if (flush) begin
                    state_next  = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dbus.ddata_ok) begin
                    state_next  = S_IDLE;
                    killed_next = 1'b0;
                end else begin
                    killed_next = killed_reg | flush;
                end
            end
            default: begin
                state_next  = S_IDLE;
                killed_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            killed_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            killed_reg <= killed_next;
        end
    end

    // A transaction flushed mid-flight still completes on the bus but never writes back
    assign wb_kill = flush | killed_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_pc       <= '0;
            wb_data     <= '0;
            wb_reg_wen  <= 1'b0;
            wb_reg_num  <= '0;
            wb_cp0_wen  <= 1'b0;
            wb_cp0_num  <= '0;
            wb_cp0_sel  <= '0;
            wb_adel     <= 1'b0;
            wb_ades     <= 1'b0;
            wb_badvaddr <= '0;
        end else if (write && !stall_out) begin
            wb_pc       <= pc;
            wb_data     <= fwd_data;
            wb_reg_wen  <= reg_wen & ~misaligned & ~wb_kill;
            wb_reg_num  <= reg_num;
            wb_cp0_wen  <= cp0_wen & ~misaligned & ~wb_kill;
            wb_cp0_num  <= cp0_num;
            wb_cp0_sel  <= cp0_sel;
            wb_adel     <= misaligned & (|mem_rd_en) & ~wb_kill;
            wb_ades     <= misaligned & (|mem_wr_en) & ~wb_kill;
            wb_badvaddr <= misaligned ? exe_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts bus,
// stall and MEM/WB behaviour per instruction; one negedge process compares.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, write, flush, ld_signed, mem_to_reg, reg_wen, cp0_wen;
    logic [31:0] pc, exe_data, busB;
    logic [3:0]  mem_rd_en, mem_wr_en;
    logic [4:0]  reg_num, cp0_num;
    logic [2:0]  cp0_sel;
    logic        stall_out;
    logic [31:0] fwd_data, wb_pc, wb_data, wb_badvaddr;
    logic        wb_reg_wen, wb_cp0_wen, wb_adel, wb_ades;
    logic [4:0]  wb_reg_num, wb_cp0_num;
    logic [2:0]  wb_cp0_sel;

    mem_access_stage_if dbus();

    mem_access_stage dut (
        .clk(clk), .rst(rst), .write(write), .flush(flush),
        .pc(pc), .exe_data(exe_data), .busB(busB),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .ld_signed(ld_signed), .mem_to_reg(mem_to_reg),
        .reg_wen(reg_wen), .reg_num(reg_num),
        .cp0_wen(cp0_wen), .cp0_num(cp0_num), .cp0_sel(cp0_sel),
        .dbus(dbus),
        .stall_out(stall_out), .fwd_data(fwd_data),
        .wb_pc(wb_pc), .wb_data(wb_data),
        .wb_reg_wen(wb_reg_wen), .wb_reg_num(wb_reg_num),
        .wb_cp0_wen(wb_cp0_wen), .wb_cp0_num(wb_cp0_num), .wb_cp0_sel(wb_cp0_sel),
        .wb_adel(wb_adel), .wb_ades(wb_ades), .wb_badvaddr(wb_badvaddr)
    );

    typedef struct {
        logic [31:0] pc, addr, b, rdata;
        logic [3:0]  rd, wr;
        logic        sgn, m2r, rwen, cwen, wr_pipe;
        logic [4:0]  rnum, cnum;
        logic [2:0]  csel;
        int          acc, dly, fl;
    } op_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle expectations
    logic        chk_en = 1'b0, wb_known = 1'b0;
    logic        e_dreq, e_stall, e_wr, e_fwd_en;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata, e_fwd;

    // Model of the MEM/WB register
    logic [31:0] m_pc, m_data, m_bad;
    logic        m_rwen, m_cwen, m_adel, m_ades;
    logic [4:0]  m_rnum, m_cnum;
    logic [2:0]  m_csel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int nbytes(input logic [3:0] enc);
        return (enc == 4'b1111) ? 4 : ((enc == 4'b0011) ? 2 : 1);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [31:0] addr,
                                               input int n, input logic sgn);
        logic [31:0] v;
        int sh;
        if (n == 4) return raw;
        sh = 8 * ((int'(addr & 32'd3) / n) * n);
        v  = raw >> sh;
        if (n == 1) begin
            v = v & 32'hFF;
            if (sgn && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = v & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] addr, input int n);
        int m;
        m = ((1 << n) - 1) << int'(addr & 32'd3);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] b, input int n);
        if (n == 1) return (b & 32'hFF) * 32'h01010101;
        if (n == 2) return (b & 32'hFFFF) * 32'h00010001;
        return b;
    endfunction

    function automatic op_t mk(input logic [31:0] pc_v, input logic [31:0] addr_v,
                               input logic [3:0] rd_v, input logic [3:0] wr_v,
                               input logic m2r_v, input logic [31:0] rdata_v,
                               input int acc_v, input int dly_v);
        op_t o;
        o.pc = pc_v; o.addr = addr_v; o.b = 32'h0; o.rdata = rdata_v;
        o.rd = rd_v; o.wr = wr_v; o.sgn = 1'b0; o.m2r = m2r_v;
        o.rwen = (wr_v == 4'b0000); o.cwen = 1'b0; o.wr_pipe = 1'b1;
        o.rnum = 5'd3; o.cnum = 5'd12; o.csel = 3'd0;
        o.acc = acc_v; o.dly = dly_v; o.fl = -1;
        return o;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_data = '0; m_bad = '0; m_rwen = 1'b0; m_cwen = 1'b0;
        m_adel = 1'b0; m_ades = 1'b0; m_rnum = '0; m_cnum = '0; m_csel = '0;
    endtask

    task automatic drive_nop();
        write = 1'b1; flush = 1'b0; pc = 32'h0; exe_data = 32'h0; busB = 32'h0;
        mem_rd_en = 4'b0; mem_wr_en = 4'b0; ld_signed = 1'b0; mem_to_reg = 1'b0;
        reg_wen = 1'b0; reg_num = 5'd0; cp0_wen = 1'b0; cp0_num = 5'd0; cp0_sel = 3'd0;
        dbus.daddr_ok = 1'b0; dbus.ddata_ok = 1'b0; dbus.drdata = 32'h0;
        e_dreq = 1'b0; e_stall = 1'b0; e_wr = 1'b0; e_size = 2'd0; e_strb = 4'd0;
        e_addr = 32'h0; e_wdata = 32'h0; e_fwd_en = 1'b1; e_fwd = 32'h0;
    endtask

    // One instruction through MEM: acc = cycles before daddr_ok, dly = cycles from
    // acceptance to ddata_ok, fl = cycle index of a one-cycle flush (-1 none).
    task automatic run_op(input op_t o);
        int n, a4, total, kend;
        bit mem, mis, issued, dropped, kill;
        logic [31:0] res;
        mem     = (o.rd != 4'b0) || (o.wr != 4'b0);
        n       = nbytes(o.rd | o.wr);
        a4      = int'(o.addr & 32'd3);
        mis     = mem && (a4 % n != 0);
        issued  = mem && !mis && (o.fl != 0);
        dropped = issued && (o.fl > 0) && (o.fl < o.acc);
        kend    = o.acc + o.dly;
        total   = !issued ? 1 : (dropped ? o.fl + 1 : kend + 1);
        kill    = (o.fl >= 0);
        res     = o.m2r ? model_load(o.rdata, o.addr, n, o.sgn) : o.addr;
        for (int k = 0; k < total; k++) begin
            rst = 1'b1; write = o.wr_pipe; flush = (k == o.fl);
            pc = o.pc; exe_data = o.addr; busB = o.b;
            mem_rd_en = o.rd; mem_wr_en = o.wr; ld_signed = o.sgn; mem_to_reg = o.m2r;
            reg_wen = o.rwen; reg_num = o.rnum; cp0_wen = o.cwen; cp0_num = o.cnum; cp0_sel = o.csel;
            dbus.drdata   = o.rdata;
            dbus.daddr_ok = issued && !dropped && (k == o.acc);
            dbus.ddata_ok = issued && !dropped && (k == kend);
            e_dreq   = issued && (k <= o.acc);
            e_stall  = issued && (dropped || k < kend);
            e_addr   = o.addr;
            e_wr     = (o.wr != 4'b0);
            e_size   = 2'(n >> 1);
            e_strb   = model_strb(o.addr, n);
            e_wdata  = model_wdata(o.b, n);
            e_fwd_en = (k == total - 1) && !dropped;
            e_fwd    = res;
            chk_en   = 1'b1;
            @(posedge clk);
            if (!e_stall && o.wr_pipe) begin
                m_pc = o.pc; m_data = res;
                m_rwen = o.rwen && !mis && !kill;
                m_cwen = o.cwen && !mis && !kill;
                m_adel = mis && (o.rd != 4'b0) && !kill;
                m_ades = mis && (o.wr != 4'b0) && !kill;
                m_bad  = mis ? o.addr : 32'h0;
                m_rnum = o.rnum; m_cnum = o.cnum; m_csel = o.csel;
            end
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dreq", dbus.dreq, e_dreq);
            chk("stall_out", stall_out, e_stall);
            if (e_dreq) begin
                chk("daddr", dbus.daddr, e_addr);
                chk("dwr", dbus.dwr, e_wr);
                chk("dsize", dbus.dsize, e_size);
                chk("dwstrb", dbus.dwstrb, e_wr ? e_strb : 4'b0000);
                if (e_wr) chk("dwdata", dbus.dwdata, e_wdata);
            end
            if (e_fwd_en) chk("fwd_data", fwd_data, e_fwd);
            if (wb_known) begin
                chk("wb_pc", wb_pc, m_pc);
                chk("wb_data", wb_data, m_data);
                chk("wb_reg_wen", wb_reg_wen, m_rwen);
                chk("wb_reg_num", wb_reg_num, m_rnum);
                chk("wb_cp0_wen", wb_cp0_wen, m_cwen);
                chk("wb_cp0_num", wb_cp0_num, m_cnum);
                chk("wb_cp0_sel", wb_cp0_sel, m_csel);
                chk("wb_adel", wb_adel, m_adel);
                chk("wb_ades", wb_ades, m_ades);
                chk("wb_badvaddr", wb_badvaddr, m_bad);
            end
        end
    end

    initial begin
        op_t o;
        rst = 1'b0;
        drive_nop();
        @(posedge clk);
        model_reset();
        wb_known = 1'b1;
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_wb_pc", wb_pc, 32'h0);
        chk("reset_wb_reg_wen", wb_reg_wen, 32'h0);

        // lw, accepted on the second cycle, data two cycles later
        o = mk(32'h400, 32'h100, 4'b1111, 4'b0, 1'b1, 32'hDEADBEEF, 1, 2);
        o.rnum = 5'd8;
        run_op(o);
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);
        chk("lw_wb_reg_wen", wb_reg_wen, 32'h1);

        // lb signed / lbu at byte 3
        o = mk(32'h404, 32'h103, 4'b0001, 4'b0, 1'b1, 32'h80112233, 0, 1);
        o.sgn = 1'b1;
        run_op(o);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        o = mk(32'h408, 32'h103, 4'b0001, 4'b0, 1'b1, 32'h80112233, 0, 1);
        run_op(o);
        chk("lbu_wb_data", wb_data, 32'h00000080);

        // sh to the upper half
        o = mk(32'h40C, 32'h102, 4'b0, 4'b0011, 1'b0, 32'h0, 0, 1);
        o.b = 32'h0000ABCD;
        chk("model_sh_strb", model_strb(32'h102, 2), 32'hC);
        chk("model_sh_wdata", model_wdata(32'h0000ABCD, 2), 32'hABCDABCD);
        run_op(o);

        // sw and sb with bus wait states
        o = mk(32'h410, 32'h104, 4'b0, 4'b1111, 1'b0, 32'h0, 2, 1);
        o.b = 32'h12345678;
        run_op(o);
        o = mk(32'h414, 32'h101, 4'b0, 4'b0001, 1'b0, 32'h0, 0, 2);
        o.b = 32'h0000775A;
        run_op(o);

        // lh signed at both halves, lhu at the upper half
        o = mk(32'h418, 32'h104, 4'b0011, 4'b0, 1'b1, 32'h80017FFF, 0, 1);
        o.sgn = 1'b1;
        run_op(o);
        chk("lh_low_wb_data", wb_data, 32'h00007FFF);
        o = mk(32'h41C, 32'h106, 4'b0011, 4'b0, 1'b1, 32'h80017FFF, 1, 1);
        o.sgn = 1'b1;
        run_op(o);
        chk("lh_high_wb_data", wb_data, 32'hFFFF8001);
        o = mk(32'h420, 32'h106, 4'b0011, 4'b0, 1'b1, 32'h80017FFF, 0, 1);
        run_op(o);

        // misaligned lw and sh
        o = mk(32'h424, 32'h1002, 4'b1111, 4'b0, 1'b1, 32'h13579BDF, 0, 1);
        run_op(o);
        chk("adel_flag", wb_adel, 32'h1);
        chk("adel_badvaddr", wb_badvaddr, 32'h1002);
        chk("adel_reg_wen", wb_reg_wen, 32'h0);
        o = mk(32'h428, 32'h101, 4'b0, 4'b0011, 1'b0, 32'h0, 0, 1);
        o.b = 32'h00001111;
        run_op(o);
        chk("ades_flag", wb_ades, 32'h1);

        // flush while waiting for data
        o = mk(32'h42C, 32'h300, 4'b1111, 4'b0, 1'b1, 32'hCAFEF00D, 0, 4);
        o.fl = 2;
        run_op(o);
        chk("flush_wait_reg_wen", wb_reg_wen, 32'h0);

        // flush in REQ before acceptance drops the request
        o = mk(32'h430, 32'h500, 4'b1111, 4'b0, 1'b1, 32'h0BADF00D, 3, 1);
        o.fl = 1;
        run_op(o);

        // ALU ops: CP0 write, CP0 write flushed, and held by write=0
        o = mk(32'h434, 32'h77, 4'b0, 4'b0, 1'b0, 32'h0, 0, 1);
        o.cwen = 1'b1; o.cnum = 5'd14; o.csel = 3'd1;
        run_op(o);
        o = mk(32'h438, 32'h88, 4'b0, 4'b0, 1'b0, 32'h0, 0, 1);
        o.cwen = 1'b1; o.fl = 0;
        run_op(o);
        chk("flush_alu_cp0_wen", wb_cp0_wen, 32'h0);
        o = mk(32'h43C, 32'h99, 4'b0, 4'b0, 1'b0, 32'h0, 0, 1);
        o.wr_pipe = 1'b0;
        run_op(o);
        chk("hold_wb_pc", wb_pc, 32'h438);

        // reset while in REQ
        o = mk(32'h440, 32'h200, 4'b1111, 4'b0, 1'b1, 32'h11111111, 3, 1);
        o.fl = 1;
        run_op(o);
        drive_nop();
        pc = 32'h444; exe_data = 32'h204; mem_rd_en = 4'b1111; mem_to_reg = 1'b1; reg_wen = 1'b1;
        e_dreq = 1'b1; e_stall = 1'b1; e_addr = 32'h204; e_size = 2'd2; e_fwd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        drive_nop();
        @(posedge clk);
        #1;
        chk("rst_dreq", dbus.dreq, 32'h0);
        chk("rst_wb_pc", wb_pc, 32'h0);
        chk("rst_wb_reg_wen", wb_reg_wen, 32'h0);
        rst = 1'b1;

        // recovery after reset
        o = mk(32'h448, 32'h108, 4'b1111, 4'b0, 1'b1, 32'h2468ACE0, 0, 1);
        run_op(o);
        chk("recover_wb_data", wb_data, 32'h2468ACE0);

        chk_en = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
